uart_tx_arbiter: RTL

Shares one UART transmit pin between NUM_REQ message sources, such as text generators and status reporters. Arbitration is round-robin at message granularity: once granted, a requester owns the line until it sends a byte flagged last, or until it stalls past a timeout. The block contains the frame serializer: start bit, 8 data bits LSB first, stop bit, then at least one idle bit before the next frame. It sits between the on-chip message sources and the tx output pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_arbiter.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART serializer types and line levels
//
// Purpose: frame state encoding and fixed UART line constants used by the
//          transmit arbiter and its helpers.
// Contents: uart_state_t, UART_DATA_BITS, UART_START_LVL, UART_STOP_LVL,
//           UART_IDLE_LVL.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick
//
// Purpose: picks the first asserted request searching upward from
//          rr_ptr+1 with wrap-around, so the last winner gets lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   rr_ptr     in  IDXW     index of the previous winner
//   next_grant out NUM_REQ  one-hot winner, zero when no request
//   next_idx   out IDXW     index of the winner, zero when no request
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] next_grant,
  output logic [IDXW-1:0]    next_idx
);

  always_comb begin
    int          cand;
    logic [IDXW-1:0] ci;
    logic        found;
    next_grant = '0;
    next_idx   = '0;
    found      = 1'b0;
    cand       = 0;
    ci         = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending on rr_ptr itself.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      ci   = IDXW'(cand);
      if (!found && req[ci]) begin
        found          = 1'b1;
        next_idx       = ci;
        next_grant[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin UART transmitter
//
// Purpose: shares one UART tx pin between NUM_REQ byte sources. A granted
//          source keeps the line until it sends a byte flagged last or
//          withholds req_valid for GAP_TIMEOUT cycles. Frames are start bit,
//          8 data bits LSB first, stop bit, then at least one idle cycle.
// Ports:
//   clk        in  1          clock
//   reset      in  1          synchronous, active-high
//   req_valid  in  NUM_REQ    byte available per source
//   req_data   in  8*NUM_REQ  byte of source i at [8i+7:8i]
//   req_last   in  NUM_REQ    byte ends its message
//   req_ready  out NUM_REQ    byte accepted when valid and ready on an edge
//   grant      out NUM_REQ    one-hot line owner, zero when unowned
//   busy       out 1          state is not IDLE
//   tx_pin     out 1          serial output, idles high
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   tx_pin
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAPW = $clog2(GAP_TIMEOUT + 1);

  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [GAPW-1:0] GAP_LAST  = GAPW'(GAP_TIMEOUT - 1);
  localparam logic [GAPW-1:0] GAP_FULL  = GAPW'(GAP_TIMEOUT);
  localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]      gidx_q, gidx_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [GAPW-1:0]      gap_q, gap_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDXW-1:0]      arb_idx;
  logic [7:0]           g_data;
  logic                 bit_done;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .next_grant (arb_grant),
    .next_idx   (arb_idx)
  );

  assign g_data   = req_data[{gidx_q, 3'b000} +: 8];
  assign bit_done = (clk_cnt_q == CNT_LAST);
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    data_d    = data_q;
    last_d    = last_q;
    req_ready = '0;
    tx_pin    = UART_IDLE_LVL;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d  = arb_grant;
          gidx_d   = arb_idx;
          rr_ptr_d = arb_idx;
          gap_d    = '0;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        req_ready = grant_q;
        if (req_valid[gidx_q]) begin
          data_d    = g_data;
          last_d    = req_last[gidx_q];
          gap_d     = '0;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end else if (gap_q >= GAP_LAST) begin
          // Owner stalled too long; rr_ptr stays on it so others go first.
          gap_d   = GAP_FULL;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAPW'(1);
        end
      end

      START: begin
        tx_pin = UART_START_LVL;
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNTW'(1);
        end
      end

      DATA: begin
        tx_pin = data_q[bit_idx_q];
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNTW'(1);
        end
      end

      STOP: begin
        tx_pin = UART_STOP_LVL;
        if (bit_done) begin
          clk_cnt_d = '0;
          if (last_q) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNTW'(1);
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= IDXW'(NUM_REQ - 1);
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      last_q    <= last_d;
    end
  end

endmodule
